// File: rtl/outbuf_pingpong_ctrl_pkg.sv
// Shared types and width helpers for the output-buffer ping-pong sequencer.
package outbuf_pingpong_ctrl_pkg;

    localparam int DST_IMG_WIDTH_DEF  = 4096;
    localparam int DST_IMG_HEIGHT_DEF = 2160;
    localparam int LINES_PER_BUF_DEF  = 4;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    // Address width for a count of n, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W = addr_w(DST_IMG_WIDTH_DEF);
    localparam int ROW_W = addr_w(DST_IMG_HEIGHT_DEF);
    localparam int LN_W  = addr_w(LINES_PER_BUF_DEF);

endpackage

// File: rtl/outbuf_pingpong_ctrl_pos.sv
// Column/line/row position counter with band-end and frame-end flags;
// one instance tracks the writer, another the reader.
module outbuf_pos_cnt #(
    parameter int W     = 4096,
    parameter int H     = 2160,
    parameter int L     = 4,
    parameter int COL_W = 12,
    parameter int ROW_W = 12,
    parameter int LN_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    output logic [COL_W-1:0] col,
    output logic [LN_W-1:0]  line,
    output logic             band_end,
    output logic             frame_end
);

    logic [COL_W-1:0] col_q, col_d;
    logic [LN_W-1:0]  line_q, line_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             row_eol;
    logic             line_last;
    logic             row_last;

    assign row_eol   = (col_q == COL_W'(W - 1));
    assign line_last = (line_q == LN_W'(L - 1));
    assign row_last  = (row_q == ROW_W'(H - 1));
    assign band_end  = row_eol & (line_last | row_last);
    assign frame_end = row_eol & row_last;
    assign col       = col_q;
    assign line      = line_q;

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        col_d  = col_q;
        line_d = line_q;
        row_d  = row_q;
        if (clear) begin
            col_d  = '0;
            line_d = '0;
            row_d  = '0;
        end else if (step) begin
            if (!row_eol) begin
                col_d = col_q + 1'b1;
            end else begin
                col_d = '0;
                if (frame_end) begin
                    line_d = '0;
                    row_d  = '0;
                end else begin
                    line_d = band_end ? '0 : line_q + 1'b1;
                    row_d  = row_q + 1'b1;
                end
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            line_q <= '0;
            row_q  <= '0;
        end else begin
            col_q  <= col_d;
            line_q <= line_d;
            row_q  <= row_d;
        end
    end

endmodule

// File: rtl/outbuf_pingpong_ctrl.sv
// Ping-pong output buffer sequencer: frame FSM, per-buffer state and
// read/write buffer selects steering the external line RAMs.
module outbuf_pingpong_ctrl
    import outbuf_pingpong_ctrl_pkg::*;
#(
    parameter int DST_IMG_WIDTH  = DST_IMG_WIDTH_DEF,
    parameter int DST_IMG_HEIGHT = DST_IMG_HEIGHT_DEF,
    parameter int LINES_PER_BUF  = LINES_PER_BUF_DEF,
    localparam int COL_W_P = addr_w(DST_IMG_WIDTH),
    localparam int ROW_W_P = addr_w(DST_IMG_HEIGHT),
    localparam int LN_W_P  = addr_w(LINES_PER_BUF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               wr_valid,
    output logic               wr_ready,
    output logic               wr_bufsel,
    output logic [LN_W_P-1:0]  wr_line,
    output logic [COL_W_P-1:0] wr_col,
    output logic               rd_avail,
    input  logic               rd_take,
    output logic               rd_bufsel,
    output logic [LN_W_P-1:0]  rd_line,
    output logic [COL_W_P-1:0] rd_col,
    output logic               rd_eol,
    output logic               frame_done,
    output logic               busy
);

    fsm_state_e state_q, state_d;
    buf_state_e buf_q [2];
    buf_state_e buf_d [2];
    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;
    logic       wr_done_q, wr_done_d;
    logic       start_clr, wr_fire, rd_fire;
    logic       wr_band_end, wr_frame_end, rd_band_end, rd_frame_end;

    outbuf_pos_cnt #(
        .W(DST_IMG_WIDTH), .H(DST_IMG_HEIGHT), .L(LINES_PER_BUF),
        .COL_W(COL_W_P), .ROW_W(ROW_W_P), .LN_W(LN_W_P)
    ) u_wr_pos (
        .clk(clk), .rst_n(rst_n), .clear(start_clr), .step(wr_fire),
        .col(wr_col), .line(wr_line),
        .band_end(wr_band_end), .frame_end(wr_frame_end)
    );

    outbuf_pos_cnt #(
        .W(DST_IMG_WIDTH), .H(DST_IMG_HEIGHT), .L(LINES_PER_BUF),
        .COL_W(COL_W_P), .ROW_W(ROW_W_P), .LN_W(LN_W_P)
    ) u_rd_pos (
        .clk(clk), .rst_n(rst_n), .clear(start_clr), .step(rd_fire),
        .col(rd_col), .line(rd_line),
        .band_end(rd_band_end), .frame_end(rd_frame_end)
    );

    assign wr_bufsel = wr_sel_q;
    assign rd_bufsel = rd_sel_q;
    assign rd_eol    = (rd_col == COL_W_P'(DST_IMG_WIDTH - 1));

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        wr_done_d  = wr_done_q;
        start_clr  = 1'b0;
        wr_ready   = 1'b0;
        rd_avail   = 1'b0;
        wr_fire    = 1'b0;
        rd_fire    = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d   = ST_RUN;
                    start_clr = 1'b1;
                    buf_d[0]  = BUF_EMPTY;
                    buf_d[1]  = BUF_EMPTY;
                    wr_sel_d  = 1'b0;
                    rd_sel_d  = 1'b0;
                    wr_done_d = 1'b0;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                wr_ready = !wr_done_q && (buf_q[wr_sel_q] != BUF_FULL);
                rd_avail = (buf_q[rd_sel_q] == BUF_FULL);
                wr_fire  = wr_valid & wr_ready;
                rd_fire  = rd_take & rd_avail;
                // Writer and reader always own different buffers, so both updates can land.
                if (wr_fire) begin
                    if (wr_band_end) begin
                        buf_d[wr_sel_q] = BUF_FULL;
                        wr_sel_d        = ~wr_sel_q;
                        wr_done_d       = wr_frame_end;
                    end else begin
                        buf_d[wr_sel_q] = BUF_FILLING;
                    end
                end
                if (rd_fire && rd_band_end) begin
                    buf_d[rd_sel_q] = BUF_EMPTY;
                    rd_sel_d        = ~rd_sel_q;
                    if (rd_frame_end) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            buf_q[0]  <= BUF_EMPTY;
            buf_q[1]  <= BUF_EMPTY;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            wr_done_q <= wr_done_d;
        end
    end

endmodule

// File: tb/tb_outbuf_pingpong_ctrl.sv
// Self-checking bench: word-index reference model of the ping-pong buffers,
// driving a 6-row instance and a 12-row instance (the latter reuses buffers).
module tb_outbuf_pingpong_ctrl;

    localparam int W   = 8;
    localparam int L   = 4;
    localparam int H_A = 6;
    localparam int H_B = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic wr_valid = 1'b0;
    logic rd_take = 1'b0;

    logic       a_wr_ready, a_wr_bufsel, a_rd_avail, a_rd_bufsel, a_rd_eol, a_frame_done, a_busy;
    logic [1:0] a_wr_line, a_rd_line;
    logic [2:0] a_wr_col, a_rd_col;
    logic       b_wr_ready, b_wr_bufsel, b_rd_avail, b_rd_bufsel, b_rd_eol, b_frame_done, b_busy;
    logic [1:0] b_wr_line, b_rd_line;
    logic [2:0] b_wr_col, b_rd_col;
    logic       o_wr_ready, o_wr_bufsel, o_rd_avail, o_rd_bufsel, o_rd_eol, o_frame_done, o_busy;
    logic [1:0] o_wr_line, o_rd_line;
    logic [2:0] o_wr_col, o_rd_col;

    int checks   = 0;
    int failures = 0;

    // Reference model: next word index for writer and reader, frame phase 0/1/2.
    int wr_n   = 0;
    int rd_n   = 0;
    int mstate = 0;
    int h_cur  = H_A;
    bit sel_big = 1'b0;

    always #5 clk = ~clk;

    outbuf_pingpong_ctrl #(.DST_IMG_WIDTH(W), .DST_IMG_HEIGHT(H_A), .LINES_PER_BUF(L)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_ready(a_wr_ready), .wr_bufsel(a_wr_bufsel),
        .wr_line(a_wr_line), .wr_col(a_wr_col),
        .rd_avail(a_rd_avail), .rd_take(rd_take), .rd_bufsel(a_rd_bufsel),
        .rd_line(a_rd_line), .rd_col(a_rd_col), .rd_eol(a_rd_eol),
        .frame_done(a_frame_done), .busy(a_busy)
    );

    outbuf_pingpong_ctrl #(.DST_IMG_WIDTH(W), .DST_IMG_HEIGHT(H_B), .LINES_PER_BUF(L)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_ready(b_wr_ready), .wr_bufsel(b_wr_bufsel),
        .wr_line(b_wr_line), .wr_col(b_wr_col),
        .rd_avail(b_rd_avail), .rd_take(rd_take), .rd_bufsel(b_rd_bufsel),
        .rd_line(b_rd_line), .rd_col(b_rd_col), .rd_eol(b_rd_eol),
        .frame_done(b_frame_done), .busy(b_busy)
    );

    always_comb begin
        o_wr_ready   = sel_big ? b_wr_ready   : a_wr_ready;
        o_wr_bufsel  = sel_big ? b_wr_bufsel  : a_wr_bufsel;
        o_wr_line    = sel_big ? b_wr_line    : a_wr_line;
        o_wr_col     = sel_big ? b_wr_col     : a_wr_col;
        o_rd_avail   = sel_big ? b_rd_avail   : a_rd_avail;
        o_rd_bufsel  = sel_big ? b_rd_bufsel  : a_rd_bufsel;
        o_rd_line    = sel_big ? b_rd_line    : a_rd_line;
        o_rd_col     = sel_big ? b_rd_col     : a_rd_col;
        o_rd_eol     = sel_big ? b_rd_eol     : a_rd_eol;
        o_frame_done = sel_big ? b_frame_done : a_frame_done;
        o_busy       = sel_big ? b_busy       : a_busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int total_words();
        return h_cur * W;
    endfunction

    // Band a word index belongs to; past the end it counts completed bands.
    function automatic int band_of(input int n);
        if (n >= total_words()) return (h_cur + L - 1) / L;
        return n / (W * L);
    endfunction

    // Word index one past the last word of band b.
    function automatic int band_end(input int b);
        int rows;
        rows = (b + 1) * L;
        if (rows > h_cur) rows = h_cur;
        return rows * W;
    endfunction

    function automatic int col_of(input int n);
        return (n >= total_words()) ? 0 : n % W;
    endfunction

    function automatic int line_of(input int n);
        return (n >= total_words()) ? 0 : (n / W) % L;
    endfunction

    // Check every output against the model, drive one cycle, advance the model.
    task automatic step(input bit wv, input bit rt, input bit fs);
        int tot, bw, br;
        bit ewr, erd;
        tot = total_words();
        bw  = band_of(wr_n);
        br  = band_of(rd_n);
        ewr = (mstate == 1) && (wr_n < tot) && (bw < 2 || rd_n >= band_end(bw - 2));
        erd = (mstate == 1) && (rd_n < tot) && (wr_n >= band_end(br));
        check("wr_ready",   o_wr_ready,   ewr);
        check("wr_bufsel",  o_wr_bufsel,  bw % 2);
        check("wr_line",    o_wr_line,    line_of(wr_n));
        check("wr_col",     o_wr_col,     col_of(wr_n));
        check("rd_avail",   o_rd_avail,   erd);
        check("rd_bufsel",  o_rd_bufsel,  br % 2);
        check("rd_line",    o_rd_line,    line_of(rd_n));
        check("rd_col",     o_rd_col,     col_of(rd_n));
        check("rd_eol",     o_rd_eol,     col_of(rd_n) == W - 1);
        check("busy",       o_busy,       mstate == 1);
        check("frame_done", o_frame_done, mstate == 2);
        wr_valid    = wv;
        rd_take     = rt & erd;
        frame_start = fs;
        @(posedge clk);
        case (mstate)
            0: if (fs) begin
                wr_n   = 0;
                rd_n   = 0;
                mstate = 1;
            end
            1: begin
                if (wv && ewr) wr_n++;
                if (rt && erd) begin
                    rd_n++;
                    if (rd_n == tot) mstate = 2;
                end
            end
            default: mstate = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic do_reset(input bit big);
        @(negedge clk);
        rst_n       = 1'b0;
        sel_big     = big;
        h_cur       = big ? H_B : H_A;
        wr_valid    = 1'b0;
        rd_take     = 1'b0;
        frame_start = 1'b0;
        wr_n        = 0;
        rd_n        = 0;
        mstate      = 0;
        #1;
        check("rst_busy",     o_busy,     0);
        check("rst_wr_ready", o_wr_ready, 0);
        check("rst_rd_avail", o_rd_avail, 0);
        check("rst_wr_col",   o_wr_col,   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic rand_frame(input string tag);
        bit seen;
        seen = 1'b0;
        step(0, 0, 1);
        check({tag, "_start_wr_ready"}, o_wr_ready, 1);
        check({tag, "_start_rd_avail"}, o_rd_avail, 0);
        check({tag, "_start_wr_col"},   o_wr_col,   0);
        check({tag, "_start_rd_line"},  o_rd_line,  0);
        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(3) != 0, $urandom_range(2) != 0, 0);
            if (o_frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_frame_done_seen"}, seen, 1);
        step(0, 0, 0);
    endtask

    initial begin
        int eol_cnt;

        // 6-row frame: directed fill, partial band, then drain.
        do_reset(1'b0);
        repeat (3) step(1, 0, 0);
        step(0, 0, 1);
        repeat (32) step(1, 0, 0);
        check("dir_buf0_full_rd_avail", o_rd_avail,  1);
        check("dir_wr_bufsel_flip",     o_wr_bufsel, 1);
        repeat (16) step(1, 0, 0);
        check("dir_partial_wr_ready", o_wr_ready,  0);
        check("dir_partial_rd_bufsel", o_rd_bufsel, 0);
        eol_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            if (i == 32) check("dir_rd_bufsel_after_32", o_rd_bufsel, 1);
            if (o_rd_eol === 1'b1) eol_cnt++;
            step(0, 1, 0);
        end
        check("dir_eol_count",  eol_cnt,      6);
        check("dir_frame_done", o_frame_done, 1);
        check("dir_busy_done",  o_busy,       0);
        step(0, 0, 0);
        check("dir_frame_done_once", o_frame_done, 0);
        step(0, 0, 0);

        do_reset(1'b0);
        rand_frame("rand_a");

        // 12-row frame: reader frees buf0 in the cycle the writer completes buf1.
        do_reset(1'b1);
        step(0, 0, 1);
        repeat (32) step(1, 0, 0);
        repeat (31) step(1, 0, 0);
        repeat (31) step(0, 1, 0);
        check("sim_pre_wr_bufsel", o_wr_bufsel, 1);
        step(1, 1, 0);
        check("sim_wr_ready_buf0", o_wr_ready,  1);
        check("sim_wr_bufsel",     o_wr_bufsel, 0);
        check("sim_rd_avail_buf1", o_rd_avail,  1);
        check("sim_rd_bufsel",     o_rd_bufsel, 1);
        repeat (10) step(1, 1, 0);

        // Reset mid-band, then a fresh randomized frame.
        do_reset(1'b1);
        rand_frame("rand_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
